// File: rtl/ram_march_bist_pkg.sv
// Shared types for the RAM march BIST: FSM state encoding and the
// phase codes reported on a failing read.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_R0W1 = 3'd2,
    ST_R1W0 = 3'd3,
    ST_R0   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  localparam logic [1:0] PH_NONE = 2'd0;
  localparam logic [1:0] PH_R0W1 = 2'd1;
  localparam logic [1:0] PH_R1W0 = 2'd2;
  localparam logic [1:0] PH_R0   = 2'd3;

endpackage

// File: rtl/ram_march_bist_if.sv
// RAM port bundle between the BIST initiator (master) and a
// synchronous-write / asynchronous-read RAM (slave).
interface ram_march_bist_if #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
);

  logic              we;
  logic [AWIDTH-1:0] waddr;
  logic [DWIDTH-1:0] wdata;
  logic              re;
  logic [AWIDTH-1:0] raddr;
  logic [DWIDTH-1:0] rdata;

  modport master (
    output we, waddr, wdata, re, raddr,
    input  rdata
  );

  modport slave (
    input  we, waddr, wdata, re, raddr,
    output rdata
  );

endinterface

// File: rtl/ram_march_bist.sv
// MATS+-style march BIST: W0 up, R0W1 up, R1W0 down, R0 down, one address
// per cycle; aborts and records address/data/phase on the first bad read.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int                AWIDTH  = 4,
  parameter int                DWIDTH  = 8,
  parameter logic [DWIDTH-1:0] PATTERN = 8'h55
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [AWIDTH-1:0]  fail_addr,
  output logic [DWIDTH-1:0]  fail_data,
  output logic [1:0]         fail_phase,
  ram_march_bist_if.master   ram
);

  localparam logic [AWIDTH-1:0] ADDR_LAST = '1;

  state_t            state_q;
  logic [AWIDTH-1:0] addr_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [AWIDTH-1:0] fail_addr_q;
  logic [DWIDTH-1:0] fail_data_q;
  logic [1:0]        fail_phase_q;

  logic              elem_we;
  logic              rd_en;
  logic [DWIDTH-1:0] wr_data;
  logic [DWIDTH-1:0] expected;
  logic [1:0]        phase;
  logic              last_addr;
  logic              mismatch;

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned, which would infer a latch.
  always_comb begin
    elem_we   = 1'b0;
    rd_en     = 1'b0;
    wr_data   = '0;
    expected  = PATTERN;
    phase     = PH_NONE;
    last_addr = 1'b0;
    unique case (state_q)
      ST_W0: begin
        elem_we   = 1'b1;
        wr_data   = PATTERN;
        last_addr = (addr_q == ADDR_LAST);
      end
      ST_R0W1: begin
        elem_we   = 1'b1;
        rd_en     = 1'b1;
        wr_data   = ~PATTERN;
        phase     = PH_R0W1;
        last_addr = (addr_q == ADDR_LAST);
      end
      ST_R1W0: begin
        elem_we   = 1'b1;
        rd_en     = 1'b1;
        wr_data   = PATTERN;
        expected  = ~PATTERN;
        phase     = PH_R1W0;
        last_addr = (addr_q == '0);
      end
      ST_R0: begin
        rd_en     = 1'b1;
        phase     = PH_R0;
        last_addr = (addr_q == '0);
      end
      default: ;
    endcase
  end

  // A failing read must not be followed by a write that would mask the fault.
  assign mismatch  = rd_en && (ram.rdata != expected);
  assign ram.we    = elem_we & ~mismatch;
  assign ram.re    = rd_en;
  assign ram.wdata = wr_data;
  assign ram.waddr = addr_q;
  assign ram.raddr = addr_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_phase_q <= PH_NONE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q      <= ST_W0;
            addr_q       <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            fail_phase_q <= PH_NONE;
          end
        end
        ST_W0: begin
          if (last_addr) begin
            state_q <= ST_R0W1;
            addr_q  <= '0;
          end else begin
            addr_q  <= addr_q + AWIDTH'(1);
          end
        end
        ST_R0W1, ST_R1W0, ST_R0: begin
          if (mismatch) begin
            state_q      <= ST_DONE;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            pass_q       <= 1'b0;
            fail_addr_q  <= addr_q;
            fail_data_q  <= ram.rdata;
            fail_phase_q <= phase;
          end else if (last_addr) begin
            if (state_q == ST_R0W1) begin
              state_q <= ST_R1W0;
              addr_q  <= ADDR_LAST;
            end else if (state_q == ST_R1W0) begin
              state_q <= ST_R0;
              addr_q  <= ADDR_LAST;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end
          end else if (state_q == ST_R0W1) begin
            addr_q <= addr_q + AWIDTH'(1);
          end else begin
            addr_q <= addr_q - AWIDTH'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign fail_phase = fail_phase_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: RAM model with injectable data-dependent read
// faults, checked against an array-level march reference model.
module tb_ram_march_bist;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SIZE = 1 << AW;
  localparam logic [DW-1:0] PAT = 8'h55;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [1:0]    fail_phase;

  ram_march_bist_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  ram_march_bist #(.AWIDTH(AW), .DWIDTH(DW), .PATTERN(PAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .fail_phase(fail_phase),
    .ram       (bus)
  );

  always #5 clk = ~clk;

  // Fault kinds: 0 none, 1 always flip at addr, 2 flip when cell holds ~PAT,
  // 3 flip when cell holds PAT.
  logic [DW-1:0] mem [SIZE];
  int            fault_kind = 0;
  int            fault_addr = 0;
  logic [DW-1:0] fault_mask = '0;

  always_ff @(posedge clk) if (bus.we) mem[bus.waddr] <= bus.wdata;

  always_comb begin
    logic [DW-1:0] v;
    logic          hit;
    v   = mem[bus.raddr];
    hit = (int'(bus.raddr) == fault_addr) &&
          ((fault_kind == 1) || (fault_kind == 2 && v == ~PAT) ||
           (fault_kind == 3 && v == PAT));
    bus.rdata = hit ? (v ^ fault_mask) : v;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: walk the march over an array of cell values.
  logic [DW-1:0] ref_mem [SIZE];
  int            exp_cycles, exp_phase, exp_addr;
  logic [DW-1:0] exp_data;
  logic          exp_pass;

  function automatic logic [DW-1:0] faulty_read(input int a, input logic [DW-1:0] v);
    if (a == fault_addr && ((fault_kind == 1) || (fault_kind == 2 && v == ~PAT) ||
                            (fault_kind == 3 && v == PAT)))
      return v ^ fault_mask;
    return v;
  endfunction

  task automatic run_model();
    logic          failed;
    logic [DW-1:0] obs, expv, wv;
    int            a;
    failed     = 1'b0;
    exp_cycles = 0;
    exp_phase  = 0;
    exp_addr   = 0;
    exp_data   = '0;
    for (int e = 0; e < 4; e++) begin
      for (int i = 0; i < SIZE; i++) begin
        if (!failed) begin
          a    = (e < 2) ? i : SIZE - 1 - i;
          expv = (e == 2) ? ~PAT : PAT;
          wv   = (e == 1) ? ~PAT : PAT;
          exp_cycles++;
          if (e > 0) begin
            obs = faulty_read(a, ref_mem[a]);
            if (obs != expv) begin
              failed    = 1'b1;
              exp_phase = e;
              exp_addr  = a;
              exp_data  = obs;
            end
          end
          if (!failed && e < 3) ref_mem[a] = wv;
        end
      end
    end
    exp_pass = !failed;
  endtask

  task automatic run_march(input string tag, input int kind, input int fa, input int fbit);
    int cyc;
    int diffs;
    fault_kind = kind;
    fault_addr = fa;
    fault_mask = DW'(1) << fbit;
    for (int i = 0; i < SIZE; i++) ref_mem[i] = DW'($urandom);
    run_model();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (busy && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, cyc, exp_cycles);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_pass"}, pass, exp_pass);
    check({tag, "_phase"}, fail_phase, exp_phase);
    check({tag, "_addr"}, fail_addr, exp_addr);
    check({tag, "_data"}, fail_data, exp_data);
    diffs = 0;
    for (int i = 0; i < SIZE; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check({tag, "_mem"}, diffs, 0);
    fault_kind = 0;
  endtask

  initial begin
    int cyc;
    int bad;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_phase", fail_phase, 2'd0);
    check("rst_we_re", {bus.we, bus.re}, 2'b00);
    rst = 1'b0;

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.we || bus.re || busy || done || bus.wdata != 0) bad++;
    end
    check("idle_quiet", bad, 0);

    run_march("clean", 0, 0, 0);
    check("clean_mem55", mem[$urandom_range(SIZE - 1)], PAT);
    run_march("stuck5", 1, 5, 0);
    check("stuck5_data", fail_data, 8'h54);
    check("stuck5_nowrite", mem[5], PAT);
    run_march("desc3", 2, 3, 7);
    check("desc3_data", fail_data, 8'h2A);

    for (int r = 0; r < 8; r++)
      run_march($sformatf("rnd%0d", r), int'($urandom_range(3)),
                int'($urandom_range(SIZE - 1)), int'($urandom_range(DW - 1)));

    // Start held high, then re-pulsed while busy: ignored.
    @(negedge clk) start = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 300) begin
      cyc++;
      if (cyc >= 30 && cyc < 40) start = cyc[0];
      if (cyc == 40) start = 1'b0;
      @(negedge clk);
    end
    check("hold_cycles", cyc, 4 * SIZE);
    check("hold_pass", {done, pass}, 2'b11);

    // Start while done restarts and clears done on the next edge.
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("restart_done", done, 1'b0);
    check("restart_busy", busy, 1'b1);

    // Reset mid-run.
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy_done", {busy, done}, 2'b00);
    check("midrst_we_re", {bus.we, bus.re}, 2'b00);
    @(negedge clk) rst = 1'b0;
    run_march("after_rst", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
